dmem_lsu: RTL

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/dmem_lsu_pkg.sv | 20 ++
 rtl/dmem_lsu_lane.sv | 60 ++++++
 rtl/dmem_lsu.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit: access sizes, FSM states
// and the default memory depth.
package dmem_lsu_pkg;

   localparam int MEM_WORDS_DEFAULT = 21;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD     = 3'd1,
      RMW_RD = 3'd2,
      WR     = 3'd3,
      RESP   = 3'd4
   } state_e;

endpackage

// File: rtl/dmem_lsu_lane.sv
// Combinational lane logic: extracts and extends load data from a memory word,
// and merges sub-word store data into a read-back word.
module dmem_lsu_lane
   import dmem_lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [1:0]  offset,
   input  logic [31:0] rword,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [3:0]  byte_en;
   logic [31:0] wrep;

   always_comb begin
      case (offset)
         2'd0:    ld_byte = rword[7:0];
         2'd1:    ld_byte = rword[15:8];
         2'd2:    ld_byte = rword[23:16];
         default: ld_byte = rword[31:24];
      endcase
      ld_half = offset[1] ? rword[31:16] : rword[15:0];

      case (size)
         SIZE_BYTE: load_data = {{24{sign_ext & ld_byte[7]}}, ld_byte};
         SIZE_HALF: load_data = {{16{sign_ext & ld_half[15]}}, ld_half};
         default:   load_data = rword;
      endcase
   end

   // Store data is replicated into every lane; the byte enables pick which lanes land.
   always_comb begin
      case (size)
         SIZE_BYTE: begin
            byte_en = 4'b0001 << offset;
            wrep    = {4{wdata[7:0]}};
         end
         SIZE_HALF: begin
            byte_en = offset[1] ? 4'b1100 : 4'b0011;
            wrep    = {2{wdata[15:0]}};
         end
         default: begin
            byte_en = 4'b1111;
            wrep    = wdata;
         end
      endcase
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign merged[gi*8 +: 8] = byte_en[gi] ? wrep[gi*8 +: 8] : rword[gi*8 +: 8];
      end
   endgenerate

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the core and a word-addressed data memory.
// Optional DMEM_LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int MEM_WORDS = MEM_WORDS_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] DMEM_address,
   output logic [31:0] DMEM_data_in,
   output logic        DMEM_mem_write,
   output logic        DMEM_mem_read,
   input  logic [31:0] DMEM_data_out
);

   localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

   state_e      state;
   logic [1:0]  size_reg;
   logic        signed_reg;
   logic [1:0]  offset_reg;
   logic [31:0] wdata_reg;

   logic [1:0]  req_offset;
   logic        req_err;
   logic [31:0] load_data;
   logic [31:0] merged;

   always_comb begin
      req_offset = req_addr[1:0];
      if (req_size == SIZE_HALF)
         req_offset[0] = 1'b0;
      else if (req_size == SIZE_WORD)
         req_offset = 2'b00;

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
      req_err = (req_size == SIZE_RSVD)
             || (req_addr[31:2] >= MEM_WORDS_W)
             || ((req_size == SIZE_HALF) && req_addr[0])
             || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
      req_err = (req_size == SIZE_RSVD) || (req_addr[31:2] >= MEM_WORDS_W);
`endif
   end

   dmem_lsu_lane u_lane (
      .size      (size_reg),
      .sign_ext  (signed_reg),
      .offset    (offset_reg),
      .rword     (DMEM_data_out),
      .wdata     (wdata_reg),
      .load_data (load_data),
      .merged    (merged)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         size_reg     <= SIZE_BYTE;
         signed_reg   <= 1'b0;
         offset_reg   <= 2'b00;
         wdata_reg    <= 32'd0;
         resp_rdata   <= 32'd0;
         resp_err     <= 1'b0;
         DMEM_address <= 32'd0;
         DMEM_data_in <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  size_reg   <= req_size;
                  signed_reg <= req_signed;
                  offset_reg <= req_offset;
                  wdata_reg  <= req_wdata;
                  if (req_err) begin
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'd0;
                     state      <= RESP;
                  end else begin
                     DMEM_address <= {2'b00, req_addr[31:2]};
                     if (!req_write) begin
                        state <= RD;
                     end else if (req_size == SIZE_WORD) begin
                        DMEM_data_in <= req_wdata;
                        state        <= WR;
                     end else begin
                        state <= RMW_RD;
                     end
                  end
               end
            end
            RD: begin
               resp_rdata <= load_data;
               resp_err   <= 1'b0;
               state      <= RESP;
            end
            RMW_RD: begin
               DMEM_data_in <= merged;
               state        <= WR;
            end
            WR: begin
               resp_rdata <= 32'd0;
               resp_err   <= 1'b0;
               state      <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Handshake and memory strobes are pure decodes of the state register.
   assign req_ready      = (state == IDLE);
   assign resp_valid     = (state == RESP);
   assign DMEM_mem_read  = (state == RD) || (state == RMW_RD);
   assign DMEM_mem_write = (state == WR);

endmodule
